// File: rtl/plic_gateway.sv
// ---------------------------------------------------------------------------
// plic_gateway
//
// Per-source interrupt gateway sitting between raw asynchronous interrupt
// pins and the PLIC priority/claim core. Each source is synchronized into
// clk_i, turned into a single pending request (level-high or rising-edge
// mode), and walked through the pending -> claimed -> completed handshake so
// that the core never sees more than one outstanding request per source.
//
// Ports:
//   clk_i       in   1        clock
//   rst_n_i     in   1        asynchronous active-low reset
//   irq_src_i   in   NUM_SRC  raw asynchronous interrupt sources
//   edge_sel_i  in   NUM_SRC  1 = rising-edge mode, 0 = level-high mode
//   claim_i     in   NUM_SRC  single-cycle claim pulse from the core
//   complete_i  in   NUM_SRC  single-cycle completion pulse from the core
//   ip_o        out  NUM_SRC  registered interrupt pending to the core
//
// Build option:
//   PLIC_GW_EDGE_CNT_EN  when defined, edges arriving while a source is
//                        pending or in service are counted in a CNT_W-bit
//                        saturating counter and each is serviced in turn.
//                        When undefined, a 1-bit hold flag remembers at most
//                        one edge seen during service.
// ---------------------------------------------------------------------------

// Per-source gateway lane.
module plic_gw_src #(
    parameter int SYNC_DEPTH = 2
`ifdef PLIC_GW_EDGE_CNT_EN
    , parameter int CNT_W    = 4
`endif
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic irq_i,
    input  logic edge_sel_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic ip_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        INSVC = 2'd2
    } state_e;

    state_e                state_q, state_n;
    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  s_d_q;
    logic                  s;
    logic                  edge_evt;
    logic                  lvl_req;
    logic                  backlog;
    logic                  ip_q;

    assign s        = sync_q[SYNC_DEPTH-1];
    // s_d resets to 0, so a source held high across reset release still
    // yields one edge event.
    assign edge_evt = edge_sel_i & s & ~s_d_q;
    assign lvl_req  = ~edge_sel_i & s;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], irq_i};
            s_d_q  <= s;
        end
    end

`ifdef PLIC_GW_EDGE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    // Gated by mode so a stale count cannot leak into a level-mode complete.
    assign backlog = edge_sel_i & ((cnt_q != '0) | edge_evt);

    always_comb begin
        cnt_n = cnt_q;
        if (state_q == PEND && edge_evt) begin
            cnt_n = cnt_inc;
        end else if (state_q == INSVC) begin
            if (complete_i) begin
                // One stored/arriving edge is consumed by the re-pend; the
                // true result is always in range, so modular math is exact.
                if (backlog) cnt_n = cnt_q + CNT_W'(edge_evt) - CNT_W'(1);
            end else if (edge_evt) begin
                cnt_n = cnt_inc;
            end
        end
        if (!edge_sel_i) cnt_n = '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_n;
    end
`else
    logic hold_q, hold_n;

    assign backlog = edge_sel_i & (hold_q | edge_evt);

    always_comb begin
        hold_n = hold_q;
        // Edges while PEND are merged into the outstanding request.
        if (state_q == INSVC) begin
            if (complete_i)    hold_n = 1'b0;
            else if (edge_evt) hold_n = 1'b1;
        end
        if (!edge_sel_i) hold_n = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) hold_q <= 1'b0;
        else          hold_q <= hold_n;
    end
`endif

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (lvl_req | edge_evt) state_n = PEND;
            PEND:    if (claim_i)            state_n = INSVC;
            INSVC:   if (complete_i)         state_n = backlog ? PEND : IDLE;
            default:                         state_n = IDLE;
        endcase
    end

    // ip is registered off the next state so it moves on the same edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ip_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            ip_q    <= (state_n == PEND);
        end
    end

    assign ip_o = ip_q;

endmodule

module plic_gateway #(
    parameter int NUM_SRC    = 8,
    parameter int SYNC_DEPTH = 2,
    parameter int CNT_W      = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic [NUM_SRC-1:0] edge_sel_i,
    input  logic [NUM_SRC-1:0] claim_i,
    input  logic [NUM_SRC-1:0] complete_i,
    output logic [NUM_SRC-1:0] ip_o
);

    if (NUM_SRC < 1 || SYNC_DEPTH < 2 || CNT_W < 1) begin : g_param_err
        $error("plic_gateway: NUM_SRC>=1, SYNC_DEPTH>=2, CNT_W>=1 required");
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        plic_gw_src #(
            .SYNC_DEPTH (SYNC_DEPTH)
`ifdef PLIC_GW_EDGE_CNT_EN
            , .CNT_W    (CNT_W)
`endif
        ) u_src (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .irq_i      (irq_src_i[i]),
            .edge_sel_i (edge_sel_i[i]),
            .claim_i    (claim_i[i]),
            .complete_i (complete_i[i]),
            .ip_o       (ip_o[i])
        );
    end

endmodule

// File: tb/tb_plic_gateway.sv
// ---------------------------------------------------------------------------
// tb_plic_gateway
//
// Scoreboard bench for plic_gateway (NUM_SRC=8, SYNC_DEPTH=2, CNT_W=2).
// Each cycle the expected ip_o vector is queued as the stimulus is driven,
// then popped and compared 1 time unit after the next rising edge.
// Sources 3,4,5,6 are edge mode; 0,1,2,7 are level mode.
// ---------------------------------------------------------------------------
module tb_plic_gateway;

    localparam int N = 8;

    logic         clk_i   = 1'b0;
    logic         rst_n_i = 1'b1;
    logic [N-1:0] irq_src_i  = '0;
    logic [N-1:0] edge_sel_i = 8'h78;
    logic [N-1:0] claim_i    = '0;
    logic [N-1:0] complete_i = '0;
    logic [N-1:0] ip_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [N-1:0] exp_q[$];
    string        tag_q[$];

    plic_gateway #(
        .NUM_SRC    (N),
        .SYNC_DEPTH (2),
        .CNT_W      (2)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .irq_src_i  (irq_src_i),
        .edge_sel_i (edge_sel_i),
        .claim_i    (claim_i),
        .complete_i (complete_i),
        .ip_o       (ip_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d checks done", n_chk);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: ip_o=%b expected %b (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push(input string tag, input logic [N-1:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic pop_chk();
        string        t;
        logic [N-1:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        chk(t, ip_o, e);
    endtask

    // One clock: queue expectation, advance past the edge, compare.
    task automatic cyc(input string tag, input logic [N-1:0] exp);
        push(tag, exp);
        @(posedge clk_i);
        #1;
        pop_chk();
    endtask

    task automatic idle(input string tag, input int n, input logic [N-1:0] exp);
        repeat (n) cyc(tag, exp);
    endtask

    // Two-cycle wide source pulse: high for one edge, low for the next.
    task automatic pulse2(input int src, input string tag,
                          input logic [N-1:0] e0, input logic [N-1:0] e1);
        irq_src_i[src] = 1'b1;
        cyc(tag, e0);
        irq_src_i[src] = 1'b0;
        cyc(tag, e1);
    endtask

    // Claim, one cycle in service, then complete.
    task automatic svc(input string tag, input logic [N-1:0] m, input logic [N-1:0] after);
        claim_i = m;
        cyc({tag, "_clm"}, '0);
        claim_i = '0;
        cyc({tag, "_svc"}, '0);
        complete_i = m;
        cyc({tag, "_cmp"}, after);
        complete_i = '0;
    endtask

    initial begin
        // ---- reset state ----
        #1 rst_n_i = 1'b0;
        #3;
        push("rst_state", '0);
        pop_chk();
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        idle("rst_idle", 10, '0);

        // ---- src0 level: latency SYNC_DEPTH+1, claim, complete low ----
        irq_src_i[0] = 1'b1;
        cyc("s0_lat1", '0);
        irq_src_i[0] = 1'b0;
        cyc("s0_lat2", '0);
        cyc("s0_lat3", 8'h01);
        idle("s0_pend", 2, 8'h01);
        svc("s0", 8'h01, '0);
        idle("s0_idle", 3, '0);

        // ---- src2 level held high ----
        irq_src_i[2] = 1'b1;
        idle("s2_lat", 2, '0);
        idle("s2_pend", 2, 8'h04);
        claim_i[2] = 1'b1;
        complete_i[2] = 1'b1;
        cyc("s2_clm_cmp", '0);
        claim_i = '0;
        complete_i = '0;
        cyc("s2_insvc", '0);
        complete_i[2] = 1'b1;
        cyc("s2_cmp_gap", '0);
        complete_i = '0;
        idle("s2_relevel", 2, 8'h04);
        claim_i[2] = 1'b1;
        cyc("s2_clm2", '0);
        claim_i = '0;
        irq_src_i[2] = 1'b0;
        idle("s2_insvc2", 3, '0);
        complete_i[2] = 1'b1;
        cyc("s2_cmp_low", '0);
        complete_i = '0;
        idle("s2_idle", 3, '0);

        // ---- src3 edge: three edges while pending ----
        pulse2(3, "s3_p1", '0, '0);
        pulse2(3, "s3_p2", 8'h08, 8'h08);
        pulse2(3, "s3_p3", 8'h08, 8'h08);
        idle("s3_pend", 2, 8'h08);
`ifdef PLIC_GW_EDGE_CNT_EN
        svc("s3_r1", 8'h08, 8'h08);
        svc("s3_r2", 8'h08, 8'h08);
        svc("s3_r3", 8'h08, '0);
`else
        svc("s3_r1", 8'h08, '0);
`endif
        idle("s3_idle", 3, '0);

        // ---- src3 edge: one edge during service -> one more round ----
        pulse2(3, "s3b_p", '0, '0);
        cyc("s3b_pend", 8'h08);
        claim_i[3] = 1'b1;
        cyc("s3b_clm", '0);
        claim_i = '0;
        pulse2(3, "s3b_hold", '0, '0);
        idle("s3b_insvc", 2, '0);
        complete_i[3] = 1'b1;
        cyc("s3b_repend", 8'h08);
        complete_i = '0;
        svc("s3b_r", 8'h08, '0);
        idle("s3b_idle", 3, '0);

        // ---- src4: complete coincides with an edge event ----
        pulse2(4, "s4_p", '0, '0);
        cyc("s4_pend", 8'h10);
        claim_i[4] = 1'b1;
        cyc("s4_clm", '0);
        claim_i = '0;
        cyc("s4_insvc", '0);
        pulse2(4, "s4_p2", '0, '0);
        complete_i[4] = 1'b1;
        cyc("s4_cmp_edge", 8'h10);
        complete_i = '0;
        svc("s4_r", 8'h10, '0);
        idle("s4_idle", 3, '0);

        // ---- src5: five edges during service ----
        pulse2(5, "s5_p", '0, '0);
        cyc("s5_pend", 8'h20);
        claim_i[5] = 1'b1;
        cyc("s5_clm", '0);
        claim_i = '0;
        for (int k = 0; k < 5; k++) pulse2(5, "s5_burst", '0, '0);
        idle("s5_insvc", 2, '0);
        complete_i[5] = 1'b1;
        cyc("s5_repend", 8'h20);
        complete_i = '0;
`ifdef PLIC_GW_EDGE_CNT_EN
        svc("s5_r1", 8'h20, 8'h20);
        svc("s5_r2", 8'h20, 8'h20);
        svc("s5_r3", 8'h20, '0);
`else
        svc("s5_r1", 8'h20, '0);
`endif
        idle("s5_idle", 3, '0);

        // ---- async reset mid-service with stored edge ----
        pulse2(6, "s6_p", '0, '0);
        cyc("s6_pend", 8'h40);
        claim_i[6] = 1'b1;
        cyc("s6_clm", '0);
        claim_i = '0;
        pulse2(6, "s6_hold", '0, '0);
        idle("s6_insvc", 2, '0);
        irq_src_i[0] = 1'b1;
        idle("s6_s0lat", 2, '0);
        idle("s6_s0pend", 2, 8'h01);
        #2 rst_n_i = 1'b0;
        #1;
        push("rst_async", '0);
        pop_chk();
        cyc("rst_held", '0);
        rst_n_i = 1'b1;
        idle("post_rst_lat", 2, '0);
        cyc("post_rst_lvl", 8'h01);
        idle("post_rst", 3, 8'h01);
        irq_src_i = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
